// File: rtl/lbist_pkg.sv
// lbist_pkg -- shared definitions for the logic-BIST adder wrapper.
//   bist_state_e       : BIST controller states
//   LFSR_TAPS_DEFAULT  : x^33 + x^20 + 1 pattern-generator feedback mask
//   LFSR_SEED_DEFAULT  : non-zero pattern-generator reload value
//   MISR_TAPS_DEFAULT  : x^17 + x^14 + 1 signature-compactor feedback mask
package lbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  localparam logic [32:0] LFSR_TAPS_DEFAULT = 33'h1_0008_0000;
  localparam logic [32:0] LFSR_SEED_DEFAULT = 33'h0_0000_0001;
  localparam logic [16:0] MISR_TAPS_DEFAULT = 17'h1_2000;

endpackage

// File: rtl/bist_misr.sv
// bist_misr -- multiple-input signature register.
// Each enabled edge shifts the register left, feeding the parity of the
// tapped bits into bit 0, then XORs in the parallel input word.
//   clk, rst  : clock, asynchronous active-high reset (clears signature)
//   clear     : synchronous clear, wins over enable
//   enable    : absorb data this edge
//   data      : W-bit word to compact
//   signature : live register contents
module bist_misr
  import lbist_pkg::*;
#(
  parameter int            W    = 17,
  parameter logic [W-1:0]  TAPS = W'(MISR_TAPS_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] signature
);

  logic [W-1:0] sig_q;
  logic         feedback;

  assign feedback  = ^(sig_q & TAPS);
  assign signature = sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clear) begin
      sig_q <= '0;
    end else if (enable) begin
      sig_q <= {sig_q[W-2:0], feedback} ^ data;
    end
  end

endmodule

// File: rtl/lbist_adder_wrapper.sv
// lbist_adder_wrapper -- N-bit registered adder with built-in self test.
// Functional mode (pin_sel=0) registers {co,sum} = a + b + cin every edge.
// Test mode (pin_sel=1) shows the MISR on pin_sum/pin_co; a level request on
// pin_bist_start (IDLE or DONE only) runs NUM_PAT LFSR patterns through the
// same adder, compacts the results in the MISR and compares against GOLDEN.
// pin_bist_start is a level, not a handshake: it is sampled only in IDLE and
// DONE with pin_sel=1, so holding it high after DONE restarts immediately.
//   pin_clk, pin_rst        : clock, asynchronous active-high reset
//   pin_a, pin_b, pin_cin   : functional operands
//   pin_sel                 : 0 functional, 1 test
//   pin_bist_start          : BIST run request
//   pin_sum, pin_co         : result register (functional) / MISR (test)
//   pin_bist_busy/done/pass : BIST status
//   pin_signature           : live MISR register
// The controller state is available as the internal signal `state`.
module lbist_adder_wrapper
  import lbist_pkg::*;
#(
  parameter int               N         = 16,
  parameter int               NUM_PAT   = 255,
  parameter logic [2*N:0]     LFSR_TAPS = (2*N+1)'(LFSR_TAPS_DEFAULT),
  parameter logic [2*N:0]     LFSR_SEED = (2*N+1)'(LFSR_SEED_DEFAULT),
  parameter logic [N:0]       MISR_TAPS = (N+1)'(MISR_TAPS_DEFAULT),
  parameter logic [N:0]       GOLDEN    = '0
) (
  input  logic         pin_clk,
  input  logic         pin_rst,
  input  logic [N-1:0] pin_a,
  input  logic [N-1:0] pin_b,
  input  logic         pin_cin,
  input  logic         pin_sel,
  input  logic         pin_bist_start,
  output logic [N-1:0] pin_sum,
  output logic         pin_co,
  output logic         pin_bist_busy,
  output logic         pin_bist_done,
  output logic         pin_bist_pass,
  output logic [N:0]   pin_signature
);

  // Holds NUM_PAT itself so the counter never wraps within a run.
  localparam int               CNT_W    = $clog2(NUM_PAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PAT - 1);

  bist_state_e      state, state_nxt;
  logic [2*N:0]     lfsr;
  logic [CNT_W-1:0] cnt;
  logic             pass;
  logic [N:0]       res;
  logic [N:0]       misr;

  logic             start_run, run_step, cmp_step, abort;

  // One adder serves both modes; pin_sel picks the operand source.
  logic [N-1:0]     op_a, op_b;
  logic             op_cin;
  logic [N:0]       add_out;

  assign op_a    = pin_sel ? lfsr[N-1:0]   : pin_a;
  assign op_b    = pin_sel ? lfsr[2*N-1:N] : pin_b;
  assign op_cin  = pin_sel ? lfsr[2*N]     : pin_cin;
  assign add_out = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, op_cin};

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    run_step  = 1'b0;
    cmp_step  = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pin_sel && pin_bist_start) begin
          start_run = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!pin_sel) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          run_step = 1'b1;
          if (cnt == CNT_LAST) state_nxt = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!pin_sel) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cmp_step  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!pin_sel) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (pin_bist_start) begin
          start_run = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Pattern generator, pattern counter and pass flag.
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      lfsr <= LFSR_SEED;
      cnt  <= '0;
      pass <= 1'b0;
    end else if (start_run) begin
      lfsr <= LFSR_SEED;
      cnt  <= '0;
      pass <= 1'b0;
    end else if (run_step) begin
      lfsr <= {lfsr[2*N-1:0], ^(lfsr & LFSR_TAPS)};
      cnt  <= cnt + CNT_W'(1);
    end else if (cmp_step) begin
      pass <= (misr == GOLDEN);
    end else if (abort) begin
      pass <= 1'b0;
    end
  end

  // Functional result register; frozen while in test mode.
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst)       res <= '0;
    else if (!pin_sel) res <= add_out;
  end

  bist_misr #(
    .W    (N + 1),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk       (pin_clk),
    .rst       (pin_rst),
    .clear     (start_run),
    .enable    (run_step),
    .data      (add_out),
    .signature (misr)
  );

  assign pin_sum       = pin_sel ? misr[N-1:0] : res[N-1:0];
  assign pin_co        = pin_sel ? misr[N]     : res[N];
  assign pin_bist_busy = (state == ST_RUN) || (state == ST_COMPARE);
  assign pin_bist_done = (state == ST_DONE);
  assign pin_bist_pass = pass;
  assign pin_signature = misr;

endmodule

// File: doc/lbist_adder_wrapper.md
LBIST_ADDER_WRAPPER -- requirements
Module: lbist_adder_wrapper

Interface
REQ-001 SHALL have parameter N, default 16, adder operand width (N >= 2).
REQ-002 SHALL have parameter NUM_PAT, default 255, number of BIST patterns per run (>= 1).
REQ-003 SHALL have parameter LFSR_TAPS, width 2N+1, default 33'h1_0008_0000 (x^33+x^20+1), pattern-generator feedback mask.
REQ-004 SHALL have parameter LFSR_SEED, width 2N+1, default 1, non-zero reload value.
REQ-005 SHALL have parameter MISR_TAPS, width N+1, default 17'h1_2000 (x^17+x^14+1), compactor feedback mask.
REQ-006 SHALL have parameter GOLDEN, width N+1, default 0, expected final signature.
REQ-007 SHALL have ports as listed; one clock; reset is asynchronous and active-high:
- pin_clk  in  1  clock
- pin_rst  in  1  asynchronous active-high reset
- pin_a  in  N  functional operand A
- pin_b  in  N  functional operand B
- pin_cin  in  1  functional carry-in
- pin_sel  in  1  0 = functional, 1 = test
- pin_bist_start  in  1  level request to run BIST
- pin_sum  out  N  registered sum (functional) / signature[N-1:0] (test)
- pin_co  out  1  registered carry (functional) / signature[N] (test)
- pin_bist_busy  out  1  high in RUN and COMPARE
- pin_bist_done  out  1  high in DONE
- pin_bist_pass  out  1  result of last completed run, valid while done
- pin_signature  out  N+1  live MISR register

Function
REQ-008 Functional mode (pin_sel=0): SHALL register {co,sum} = pin_a + pin_b + pin_cin each edge; latency 1 cycle; N+1-bit result, no truncation.
REQ-009 Test mode (pin_sel=1): pin_sum/pin_co SHALL be driven combinationally from the MISR register; the functional result register holds its value.
REQ-010 FSM states SHALL be IDLE, RUN, COMPARE, DONE.
REQ-011 IDLE or DONE, pin_sel=1, pin_bist_start=1 at an edge: lfsr <= LFSR_SEED, misr <= 0, cnt <= 0, done <= 0, pass <= 0, state <= RUN.
REQ-012 RUN, each edge: operands a = lfsr[N-1:0], b = lfsr[2N-1:N], cin = lfsr[2N]; misr <= {misr[N-1:0], ^(misr & MISR_TAPS)} XOR {co,sum}; lfsr <= {lfsr[2N-1:0], ^(lfsr & LFSR_TAPS)}; cnt++.
REQ-013 RUN with cnt == NUM_PAT-1 at an edge: SHALL perform that final update and move to COMPARE; exactly NUM_PAT patterns absorbed.
REQ-014 COMPARE: pass <= (misr == GOLDEN), done <= 1, state <= DONE; done SHALL therefore rise NUM_PAT+1 edges after the start edge.
REQ-015 DONE SHALL hold done, pass and misr until a new start or pin_sel=0.
REQ-016 pin_bist_start SHALL be ignored in RUN and COMPARE, and in any state while pin_sel=0.
REQ-017 pin_sel falling to 0 in RUN, COMPARE or DONE SHALL return the FSM to IDLE at the next edge, clearing busy, done and pass; the misr value is retained.
REQ-018 cnt width SHALL be $clog2(NUM_PAT+1); no wrap-around is permitted within a run.

Reset
REQ-019 pin_rst=1 SHALL asynchronously force state=IDLE, lfsr=LFSR_SEED, misr=0, cnt=0, result register=0, busy=done=pass=0, so that pin_sum, pin_co and pin_signature read 0.
REQ-020 Reset asserted mid-RUN SHALL abort the run with no partial pass/done indication; after release the block SHALL wait in IDLE.

Structure
REQ-021 The FSM state enum and default tap constants SHALL live in shared package lbist_pkg.
REQ-022 The MISR SHALL be a sub-module, bist_misr, parametrised by width and taps; the LFSR and FSM SHALL stay in the top.

Verification
REQ-023 Functional: pin_sel=0, a=16'hFFFF, b=16'h0001, cin=0 -> next edge pin_sum=16'h0000, pin_co=1.
REQ-024 First pattern: seed=1, start -> after first RUN edge pin_signature=17'h00001.
REQ-025 Full run: NUM_PAT=4, GOLDEN taken from a reference model -> busy for 5 cycles, done at start+5 edges, pass=1; with GOLDEN altered, pass=0.
REQ-026 Abort: pin_sel dropped at cnt=2 -> next edge busy=0, done=0, pass=0, state IDLE.
REQ-027 Start held high through RUN -> no restart and cnt monotonic; start still high in DONE -> restart on the next edge, done=0.
REQ-028 pin_rst pulsed mid-RUN between edges -> outputs 0 immediately; no done after release until a new start.
